vector_list_player: RTL and testbench

//  Display-list sequencer feeding the vector control stage (x, y, jump, draw, ready).

---
 rtl/vector_pkg.sv | 35 +++
 rtl/list_ram.sv | 25 ++
 rtl/vector_list_player.sv | 147 ++++++++++++++
 tb/tb_vector_list_player.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// rtl/vector_pkg.sv - shared types and field layout for the vector display-list player
package vector_pkg;

    localparam int COORD_W = 12;
    localparam int CMD_W   = 26;

    // Command word layout: {op[1:0], x[11:0], y[11:0]}
    localparam int OP_HI = 25;
    localparam int OP_LO = 24;
    localparam int X_HI  = 23;
    localparam int X_LO  = 12;
    localparam int Y_HI  = 11;
    localparam int Y_LO  = 0;

    typedef enum logic [1:0] {
        OP_JUMP = 2'b00,
        OP_DRAW = 2'b01,
        OP_END  = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_HOLDOFF,
        ST_WAIT_RDY
    } state_t;

    function automatic op_t cmd_op(input logic [CMD_W-1:0] cmd);
        return op_t'(cmd[OP_HI:OP_LO]);
    endfunction

endpackage

// File: rtl/list_ram.sv
// rtl/list_ram.sv - two-bank display-list RAM, one write port and one synchronous read port
module list_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 26
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Address MSB selects the bank; both banks live in one array
    logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    // Host write plus registered read; contents are never cleared
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vector_list_player.sv
// rtl/vector_list_player.sv - double-buffered display-list sequencer driving the vector control stage
module vector_list_player
    import vector_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int HOLDOFF = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [CMD_W-1:0]   wr_data,
    input  logic               swap_req,
    output logic               swap_pend,
    output logic               bank,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               jump,
    output logic               draw,
    input  logic               ready,
    output logic               frame_start
);

    localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t             state;
    logic [ADDR_W-1:0]  rd_addr;
    logic [HC_W-1:0]    hold_cnt;
    logic [CMD_W-1:0]   rd_data;
    op_t                rd_op;
    logic               at_last;
    logic               wrap_now;

    // Host always writes the bank that is not being replayed, so the two ports never collide
    list_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (CMD_W)
    ) u_list_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({~bank, wr_addr}),
        .wr_data (wr_data),
        .rd_addr ({bank, rd_addr}),
        .rd_data (rd_data)
    );

    assign rd_op   = cmd_op(rd_data);
    assign at_last = (rd_addr == {ADDR_W{1'b1}});

    // Frame wrap: explicit END, or stepping past the last address (implicit END)
    always_comb begin
        wrap_now = 1'b0;
        if (state == ST_DECODE && enable &&
            (rd_op == OP_END || (rd_op == OP_NOP && at_last))) begin
            wrap_now = 1'b1;
        end
        if (state == ST_ISSUE && ready && at_last) begin
            wrap_now = 1'b1;
        end
    end

    // Sequencer FSM with registered beam outputs, bank and swap bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rd_addr     <= '0;
            hold_cnt    <= '0;
            bank        <= 1'b0;
            swap_pend   <= 1'b0;
            x           <= '0;
            y           <= '0;
            jump        <= 1'b0;
            draw        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            jump        <= 1'b0;
            draw        <= 1'b0;
            frame_start <= 1'b0;
            if (swap_req) begin
                swap_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        rd_addr     <= '0;
                        frame_start <= 1'b1;
                        state       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    // NOP/END are command boundaries, so a dropped enable stops here
                    case (rd_op)
                        OP_JUMP, OP_DRAW: state <= ST_ISSUE;
                        OP_NOP: begin
                            rd_addr <= rd_addr + 1'b1;
                            state   <= enable ? ST_FETCH : ST_IDLE;
                        end
                        OP_END: begin
                            state <= enable ? ST_FETCH : ST_IDLE;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    // rd_data still holds this command: same address, same bank since FETCH
                    if (ready) begin
                        x        <= rd_data[X_HI:X_LO];
                        y        <= rd_data[Y_HI:Y_LO];
                        jump     <= (rd_op == OP_JUMP);
                        draw     <= (rd_op == OP_DRAW);
                        rd_addr  <= rd_addr + 1'b1;
                        hold_cnt <= HC_W'(HOLDOFF - 1);
                        state    <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state <= ST_WAIT_RDY;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    if (ready) begin
                        state <= enable ? ST_FETCH : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A swap requested in the wrap cycle itself is taken at this wrap
            if (wrap_now) begin
                rd_addr     <= '0;
                frame_start <= 1'b1;
                if (swap_pend || swap_req) begin
                    bank      <= ~bank;
                    swap_pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_list_player.sv
// tb/tb_vector_list_player.sv - randomized self-checking bench for vector_list_player
module tb_vector_list_player;

    localparam int DEPTH = 512;

    typedef struct {
        int kind;
        int x;
        int y;
        int cyc;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [25:0] wr_data;
    logic        swap_req;
    logic        swap_pend;
    logic        bank;
    logic [11:0] x;
    logic [11:0] y;
    logic        jump;
    logic        draw;
    logic        ready;
    logic        frame_start;

    logic        ready_man;
    logic        ready_rand;
    logic        rand_mode;
    logic        rdy_q;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          exp_bank;
    logic [25:0] model_mem [0:1][0:DEPTH-1];
    logic [25:0] list_q[$];
    ev_t         exp_q[$];
    ev_t         got_q[$];
    bit          cap_ok;
    int          cap_bank;
    int          cap_viol;

    vector_list_player #(
        .ADDR_W  (9),
        .HOLDOFF (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_pend   (swap_pend),
        .bank        (bank),
        .x           (x),
        .y           (y),
        .jump        (jump),
        .draw        (draw),
        .ready       (ready),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ready = rand_mode ? ready_rand : ready_man;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rdy_q <= ready;
    end

    always @(negedge clk) begin
        ready_rand = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [25:0] mk(input logic [1:0] op, input int xx, input int yy);
        logic [11:0] xs;
        logic [11:0] ys;
        xs = xx[11:0];
        ys = yy[11:0];
        return {op, xs, ys};
    endfunction

    // Reference: a frame is every JUMP/DRAW from address 0 up to the first END or the end of the bank
    task automatic model_frame(input int b);
        logic [1:0] op;
        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            op = model_mem[b][a][25:24];
            if (op == 2'b10) break;
            if (op == 2'b00 || op == 2'b01) begin
                exp_q.push_back('{kind: int'(op == 2'b01), x: int'(model_mem[b][a][23:12]),
                                  y: int'(model_mem[b][a][11:0]), cyc: 0});
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i].kind != exp_q[i].kind || got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y)
                return i;
        end
        return (got_q.size() == exp_q.size()) ? -1 : n;
    endfunction

    task automatic host_write(input int addr, input logic [25:0] data);
        wr_en   = 1'b1;
        wr_addr = addr[8:0];
        wr_data = data;
        model_mem[(exp_bank == 0) ? 1 : 0][addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_list();
        for (int i = 0; i < list_q.size(); i++) host_write(i, list_q[i]);
    endtask

    task automatic gen_list(input int n);
        int r;
        list_q.delete();
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            list_q.push_back(mk((r < 4) ? 2'b00 : (r < 8) ? 2'b01 : 2'b11,
                                $urandom_range(0, 4095), $urandom_range(0, 4095)));
        end
        list_q.push_back(mk(2'b10, 0, 0));
    endtask

    task automatic swap_pulse();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic wait_fs(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pulse(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (jump || draw) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Record pulses up to and including the next frame_start cycle
    task automatic capture_rest(input int bound);
        got_q.delete();
        cap_ok   = 1'b0;
        cap_viol = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (jump || draw) begin
                if (jump && draw) cap_viol++;
                if (!rdy_q) cap_viol++;
                got_q.push_back('{kind: int'(draw), x: int'(x), y: int'(y), cyc: cyc});
            end
            if (frame_start) begin
                cap_ok   = 1'b1;
                cap_bank = int'(bank);
                break;
            end
        end
    endtask

    task automatic test_reset();
        int fs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bank, swap_pend, jump, draw, frame_start} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000", {bank, swap_pend, jump, draw, frame_start});
        end
        n_tests++;
        if (x !== 12'd0 || y !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_xy: got %0d/%0d required 0/0", x, y);
        end
        reset = 1'b0;
        fs = 0;
        repeat (5) begin
            @(negedge clk);
            if (frame_start || jump || draw) fs++;
        end
        n_tests++;
        if (fs != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d events required 0", fs);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int d;
        list_q.delete();
        list_q.push_back(mk(2'b00, 100, 200));
        list_q.push_back(mk(2'b01, 300, 400));
        list_q.push_back(mk(2'b10, 0, 0));
        load_list();
        swap_pulse();
        n_tests++;
        if (swap_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pend: got %b required 1", swap_pend);
        end
        ready_man = 1'b1;
        enable    = 1'b1;
        wait_fs(10, ok);
        n_tests++;
        if (!ok || bank !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_first_fs: seen %0d bank %b required seen 1 bank 0", ok, bank);
        end
        wait_fs(8000, ok);
        n_tests++;
        if (!ok || bank !== 1'b1 || swap_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_swap: seen %0d bank %b pend %b required 1 1 0", ok, bank, swap_pend);
        end
        exp_bank = 1;
        model_frame(1);
        capture_rest(200);
        d = first_diff();
        n_tests++;
        if (!cap_ok || d != -1) begin
            n_fail++;
            $display("FAIL basic_frame: wrapped %0d diff at %0d got %0d events required %0d", cap_ok, d,
                     got_q.size(), exp_q.size());
        end else begin
            n_tests++;
            if (got_q[1].cyc - got_q[0].cyc != 6) begin
                n_fail++;
                $display("FAIL basic_spacing: got %0d cycles required 6", got_q[1].cyc - got_q[0].cyc);
            end
        end
    endtask

    task automatic test_ready_stall();
        bit ok;
        int cnt;
        int lat;
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            wait_pulse(100, ok);
            if (ok && !jump) ok = 1'b0;
        end
        ready_man = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (jump || draw) cnt++;
        end
        n_tests++;
        if (!ok || cnt != 0 || x !== 12'd100 || y !== 12'd200) begin
            n_fail++;
            $display("FAIL stall_hold: jump_seen %0d pulses %0d xy %0d/%0d required 1 0 100/200", ok, cnt, x, y);
        end
        ready_man = 1'b1;
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 10 && !ok; i++) begin
            @(negedge clk);
            if (jump || draw) begin
                ok  = 1'b1;
                lat = i;
            end
        end
        n_tests++;
        if (!ok || lat != 4 || draw !== 1'b1 || x !== 12'd300 || y !== 12'd400) begin
            n_fail++;
            $display("FAIL stall_release: latency %0d draw %b xy %0d/%0d required 4 1 300/400", lat, draw, x, y);
        end
    endtask

    task automatic test_swap_pending();
        bit ok;
        int d;
        gen_list($urandom_range(3, 10));
        load_list();
        wait_fs(200, ok);
        wait_pulse(100, ok);
        swap_pulse();
        n_tests++;
        if (swap_pend !== 1'b1 || bank !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set: pend %b bank %b required 1 1", swap_pend, bank);
        end
        swap_pulse();
        n_tests++;
        if (swap_pend !== 1'b1 || bank !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_repeat: pend %b bank %b required 1 1", swap_pend, bank);
        end
        capture_rest(200);
        n_tests++;
        if (!cap_ok || cap_bank != 0 || swap_pend !== 1'b0 || got_q.size() != 1 ||
            (got_q.size() == 1 && (got_q[0].kind != 1 || got_q[0].x != 300 || got_q[0].y != 400))) begin
            n_fail++;
            $display("FAIL pend_take: wrapped %0d bank %0d pend %b events %0d required 1 0 0 1(draw 300/400)",
                     cap_ok, cap_bank, swap_pend, got_q.size());
        end
        exp_bank = 0;
        model_frame(0);
        capture_rest(500);
        d = first_diff();
        n_tests++;
        if (!cap_ok || d != -1) begin
            n_fail++;
            $display("FAIL pend_frame: wrapped %0d diff at %0d got %0d events required %0d", cap_ok, d,
                     got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d;
        for (int r = 0; r < 3; r++) begin
            gen_list($urandom_range(4, 12));
            load_list();
            swap_pulse();
            wait_fs(500, ok);
            n_tests++;
            if (!ok || int'(bank) == exp_bank) begin
                n_fail++;
                $display("FAIL b2b_swap%0d: seen %0d bank %b required 1 %0d", r, ok, bank, 1 - exp_bank);
            end
            exp_bank = 1 - exp_bank;
            model_frame(exp_bank);
            rand_mode = 1'b1;
            fork
                capture_rest(2000);
                for (int k = 0; k < 20; k++)
                    host_write($urandom_range(0, DEPTH - 1), 26'($urandom));
            join
            rand_mode = 1'b0;
            d = first_diff();
            n_tests++;
            if (!cap_ok || d != -1 || cap_viol != 0) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: wrapped %0d diff at %0d violations %0d got %0d required %0d",
                         r, cap_ok, d, cap_viol, got_q.size(), exp_q.size());
            end
        end
    endtask

    task automatic test_end_only();
        bit ok;
        int fs;
        int pulses;
        list_q.delete();
        list_q.push_back(mk(2'b10, 0, 0));
        load_list();
        swap_pulse();
        wait_fs(500, ok);
        n_tests++;
        if (!ok || int'(bank) == exp_bank) begin
            n_fail++;
            $display("FAIL endonly_swap: seen %0d bank %b required 1 %0d", ok, bank, 1 - exp_bank);
        end
        exp_bank = 1 - exp_bank;
        fs = 0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (frame_start) fs++;
            if (jump || draw) pulses++;
        end
        n_tests++;
        if (fs != 20 || pulses != 0) begin
            n_fail++;
            $display("FAIL endonly_loop: frame_starts %0d pulses %0d required 20 0", fs, pulses);
        end
        wait_fs(10, ok);
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        n_tests++;
        if (frame_start !== 1'b1 || int'(bank) == exp_bank || swap_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL swap_at_wrap: fs %b bank %b pend %b required 1 %0d 0", frame_start, bank, swap_pend,
                     1 - exp_bank);
        end
        exp_bank = 1 - exp_bank;
    endtask

    task automatic test_no_end();
        bit ok;
        int d;
        int mid;
        mid = $urandom_range(1, DEPTH - 2);
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 0)              host_write(a, mk(2'b00, $urandom_range(0, 4095), $urandom_range(0, 4095)));
            else if (a == mid)       host_write(a, mk(2'b00, $urandom_range(0, 4095), $urandom_range(0, 4095)));
            else if (a == DEPTH - 1) host_write(a, mk(2'b01, $urandom_range(0, 4095), $urandom_range(0, 4095)));
            else                     host_write(a, mk(2'b11, 0, 0));
        end
        swap_pulse();
        wait_fs(500, ok);
        exp_bank = 1 - exp_bank;
        n_tests++;
        if (!ok || int'(bank) != exp_bank) begin
            n_fail++;
            $display("FAIL noend_swap: seen %0d bank %b required 1 %0d", ok, bank, exp_bank);
        end
        model_frame(exp_bank);
        capture_rest(5000);
        d = first_diff();
        n_tests++;
        if (!cap_ok || d != -1 || got_q.size() != 3) begin
            n_fail++;
            $display("FAIL noend_frame: wrapped %0d diff at %0d got %0d events required 3", cap_ok, d, got_q.size());
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        int cnt;
        wait_pulse(100, ok);
        enable = 1'b0;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (jump || draw || frame_start) cnt++;
        end
        n_tests++;
        if (!ok || cnt != 0) begin
            n_fail++;
            $display("FAIL enable_drop: pulse_seen %0d events after drop %0d required 1 0", ok, cnt);
        end
        enable = 1'b1;
        @(negedge clk);
        n_tests++;
        if (frame_start !== 1'b1 || int'(bank) != exp_bank) begin
            n_fail++;
            $display("FAIL reenable_fs: fs %b bank %b required 1 %0d", frame_start, bank, exp_bank);
        end
        model_frame(exp_bank);
        wait_pulse(20, ok);
        n_tests++;
        if (!ok || int'(draw) != exp_q[0].kind || int'(x) != exp_q[0].x || int'(y) != exp_q[0].y) begin
            n_fail++;
            $display("FAIL reenable_first: seen %0d draw %b xy %0d/%0d required draw %0d xy %0d/%0d", ok, draw,
                     x, y, exp_q[0].kind, exp_q[0].x, exp_q[0].y);
        end
    endtask

    task automatic test_reset_holdoff();
        bit ok;
        swap_pulse();
        wait_pulse(3000, ok);
        reset = 1'b1;
        #1;
        n_tests++;
        if (!ok || {bank, swap_pend, jump, draw, frame_start} !== 5'b0 || x !== 12'd0 || y !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_mid: seen %0d flags %b xy %0d/%0d required 1 00000 0/0", ok,
                     {bank, swap_pend, jump, draw, frame_start}, x, y);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (frame_start !== 1'b1 || bank !== 1'b0 || swap_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_restart: fs %b bank %b pend %b required 1 0 0", frame_start, bank, swap_pend);
        end
        exp_bank = 0;
        model_frame(0);
        wait_pulse(20, ok);
        n_tests++;
        if (!ok || int'(draw) != exp_q[0].kind || int'(x) != exp_q[0].x || int'(y) != exp_q[0].y) begin
            n_fail++;
            $display("FAIL reset_first: seen %0d draw %b xy %0d/%0d required draw %0d xy %0d/%0d", ok, draw,
                     x, y, exp_q[0].kind, exp_q[0].x, exp_q[0].y);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        exp_bank   = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        swap_req   = 1'b0;
        ready_man  = 1'b0;
        rand_mode  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ready_stall();
        test_swap_pending();
        test_back_to_back();
        test_end_only();
        test_no_end();
        test_enable_drop();
        test_reset_holdoff();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
